// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
// writeback_unit_if : producer handshakes and register-file write port of the
//                     RV32I write-back stage. Revision 1.0
// ============================================================================
interface writeback_unit_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ready;

    logic             lsu_valid;
    logic [4:0]       lsu_rd;
    logic [WIDTH-1:0] lsu_data;
    logic [2:0]       lsu_funct3;
    logic [1:0]       lsu_byte_off;
    logic             lsu_ready;

    logic             rf_write_en;
    logic [WIDTH-1:0] rf_write_addr;
    logic [WIDTH-1:0] rf_data_in;
    logic [DEPTH-1:0] rd_pending_mask;
    logic             err_illegal_load;

    modport master (
        output alu_valid, alu_rd, alu_result,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_byte_off,
        input  lsu_ready,
        input  rf_write_en, rf_write_addr, rf_data_in, rd_pending_mask, err_illegal_load
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_byte_off,
        output lsu_ready,
        output rf_write_en, rf_write_addr, rf_data_in, rd_pending_mask, err_illegal_load
    );
endinterface
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// writeback_unit : formats loads, buffers two results in order and drains
//                  one register-file write per cycle. Revision 1.0
// ============================================================================
module writeback_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    writeback_unit_if.slave wb
);
    localparam logic [1:0] c_CNT_EMPTY = 2'd0;
    localparam logic [1:0] c_CNT_ONE   = 2'd1;
    localparam logic [1:0] c_CNT_FULL  = 2'd2;

    logic [1:0]       count_q, count_d;
    logic [4:0]       head_rd_q, head_rd_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic [4:0]       tail_rd_q, tail_rd_d;
    logic [WIDTH-1:0] tail_data_q, tail_data_d;
    logic             err_q, err_d;

    logic             w_lsu_ready, w_alu_ready;
    logic             w_lsu_fire, w_alu_fire;
    logic             w_lsu_push, w_alu_push;
    logic             w_pop;
    logic [1:0]       w_rem;
    logic             w_p0_valid, w_p1_valid;
    logic [4:0]       w_p0_rd;
    logic [WIDTH-1:0] w_p0_data;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load_data;
    logic             w_illegal;
    logic [DEPTH-1:0] w_mask;

    // Readiness looks only at the registered count; no credit for this cycle's pop.
    assign w_lsu_ready = !rst && (count_q <= c_CNT_ONE);
    assign w_alu_ready = !rst && (wb.lsu_valid ? (count_q == c_CNT_EMPTY)
                                               : (count_q <= c_CNT_ONE));
    assign w_lsu_fire  = wb.lsu_valid && w_lsu_ready;
    assign w_alu_fire  = wb.alu_valid && w_alu_ready;
    assign w_lsu_push  = w_lsu_fire && (wb.lsu_rd != 5'd0);
    assign w_alu_push  = w_alu_fire && (wb.alu_rd != 5'd0);
    assign w_pop       = (count_q != c_CNT_EMPTY);

    always_comb begin
        w_byte      = 8'h00;
        w_load_data = '0;
        w_illegal   = 1'b0;
        case (wb.lsu_byte_off)
            2'd0:    w_byte = wb.lsu_data[7:0];
            2'd1:    w_byte = wb.lsu_data[15:8];
            2'd2:    w_byte = wb.lsu_data[23:16];
            default: w_byte = wb.lsu_data[31:24];
        endcase
        w_half = wb.lsu_byte_off[1] ? wb.lsu_data[31:16] : wb.lsu_data[15:0];
        case (wb.lsu_funct3)
            3'b000:  w_load_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(WIDTH-16){w_half[15]}}, w_half};
            3'b010:  w_load_data = wb.lsu_data;
            3'b100:  w_load_data = {{(WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(WIDTH-16){1'b0}}, w_half};
            default: w_illegal   = 1'b1;
        endcase
    end

    always_comb begin
        head_rd_d   = head_rd_q;
        head_data_d = head_data_q;
        tail_rd_d   = tail_rd_q;
        tail_data_d = tail_data_q;
        err_d       = w_lsu_fire && w_illegal;
        w_rem       = count_q - {1'b0, w_pop};

        // The load is the older of a same-cycle pair, so it takes the first slot.
        w_p0_valid = w_lsu_push || w_alu_push;
        w_p1_valid = w_lsu_push && w_alu_push;
        w_p0_rd    = w_lsu_push ? wb.lsu_rd : wb.alu_rd;
        w_p0_data  = w_lsu_push ? w_load_data : wb.alu_result;

        if (w_pop) begin
            head_rd_d   = tail_rd_q;
            head_data_d = tail_data_q;
        end

        if (w_rem == c_CNT_EMPTY) begin
            if (w_p0_valid) begin
                head_rd_d   = w_p0_rd;
                head_data_d = w_p0_data;
            end
            if (w_p1_valid) begin
                tail_rd_d   = wb.alu_rd;
                tail_data_d = wb.alu_result;
            end
        end else if (w_p0_valid) begin
            tail_rd_d   = w_p0_rd;
            tail_data_d = w_p0_data;
        end

        count_d = w_rem + {1'b0, w_p0_valid} + {1'b0, w_p1_valid};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= c_CNT_EMPTY;
            head_rd_q   <= 5'd0;
            head_data_q <= '0;
            tail_rd_q   <= 5'd0;
            tail_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_rd_q   <= head_rd_d;
            head_data_q <= head_data_d;
            tail_rd_q   <= tail_rd_d;
            tail_data_q <= tail_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        w_mask = '0;
        if (count_q != c_CNT_EMPTY) w_mask[head_rd_q] = 1'b1;
        if (count_q == c_CNT_FULL)  w_mask[tail_rd_q] = 1'b1;
    end

    // The write strobe is held off during reset so entries being discarded never commit.
    assign wb.alu_ready        = w_alu_ready;
    assign wb.lsu_ready        = w_lsu_ready;
    assign wb.rf_write_en      = w_pop && !rst;
    assign wb.rf_write_addr    = (w_pop && !rst) ? {{(WIDTH-5){1'b0}}, head_rd_q} : '0;
    assign wb.rf_data_in       = (w_pop && !rst) ? head_data_q : '0;
    assign wb.rd_pending_mask  = w_mask;
    assign wb.err_illegal_load = err_q;
endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// tb_writeback_unit : directed and randomized bench for writeback_unit with a
//                     queue-based reference model. Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_writeback_unit;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) wb ();
    writeback_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes in program order plus the error pulse.
    logic [4:0]  m_rd[$];
    logic [31:0] m_data[$];
    bit          m_err = 1'b0;

    // Actual writes seen at the register-file port.
    logic [4:0]  log_rd[$];
    logic [31:0] log_data[$];
    always @(negedge clk) begin
        if (wb.rf_write_en === 1'b1) begin
            log_rd.push_back(wb.rf_write_addr[4:0]);
            log_data.push_back(wb.rf_data_in);
        end
    end

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w,
                                             input logic [1:0] off);
        int unsigned byte_v, half_v;
        byte_v = (w >> (8 * off)) & 32'hFF;
        half_v = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (byte_v >= 128)   ? byte_v - 256   : byte_v;
            3'b001:  return (half_v >= 32768) ? half_v - 65536 : half_v;
            3'b010:  return w;
            3'b100:  return byte_v;
            3'b101:  return half_v;
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick(output bit lf, output bit af);
        bit lr, ar, illegal;
        logic [4:0]  lrd, ard;
        logic [31:0] lval, aval;
        lr = !rst && (m_rd.size() <= 1);
        ar = !rst && (wb.lsu_valid ? (m_rd.size() == 0) : (m_rd.size() <= 1));
        lf = wb.lsu_valid && lr;
        af = wb.alu_valid && ar;
        lrd = wb.lsu_rd;
        ard = wb.alu_rd;
        lval = ref_load(wb.lsu_funct3, wb.lsu_data, wb.lsu_byte_off);
        aval = wb.alu_result;
        illegal = !(wb.lsu_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        @(posedge clk);
        if (rst) begin
            m_rd.delete();
            m_data.delete();
            m_err = 1'b0;
        end else begin
            if (m_rd.size() != 0) begin
                void'(m_rd.pop_front());
                void'(m_data.pop_front());
            end
            m_err = lf && illegal;
            if (lf && lrd != 5'd0) begin m_rd.push_back(lrd); m_data.push_back(lval); end
            if (af && ard != 5'd0) begin m_rd.push_back(ard); m_data.push_back(aval); end
        end
        #1;
    endtask

    task automatic step();
        bit lf, af;
        tick(lf, af);
    endtask

    task automatic drive_idle();
        wb.alu_valid = 1'b0; wb.alu_rd = 5'd0; wb.alu_result = 32'h0;
        wb.lsu_valid = 1'b0; wb.lsu_rd = 5'd0; wb.lsu_data = 32'h0;
        wb.lsu_funct3 = 3'b010; wb.lsu_byte_off = 2'd0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_result = 32'hDEAD_0009;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd8;
        step(); step();
        checks++;
        if ({wb.alu_ready, wb.lsu_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b exp 00", {wb.alu_ready, wb.lsu_ready});
        end
        drive_idle();
        rst = 1'b0;
        #1;
        checks++;
        if ({wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask, wb.err_illegal_load} !== '0) begin
            errors++; $display("FAIL reset_outputs got we=%b addr=%h data=%h mask=%h err=%b exp all 0",
                wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask, wb.err_illegal_load);
        end
        checks++;
        if ({wb.alu_ready, wb.lsu_ready} !== 2'b11) begin
            errors++; $display("FAIL idle_ready got %b exp 11", {wb.alu_ready, wb.lsu_ready});
        end
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_result = 32'h1234_5678;
        #1; step();
        wb.alu_valid = 1'b0;
        #1;
        checks++;
        if ({wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask} !== {1'b1, 32'd5, 32'h1234_5678, 32'h20}) begin
            errors++; $display("FAIL idle_write got we=%b addr=%h data=%h mask=%h exp 1/5/12345678/20",
                wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask);
        end
        step();
        checks++;
        if ({wb.rf_write_en, wb.rd_pending_mask} !== 33'h0) begin
            errors++; $display("FAIL idle_after got we=%b mask=%h exp 0/0", wb.rf_write_en, wb.rd_pending_mask);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  offs [5] = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            wb.lsu_valid = 1'b1; wb.lsu_rd = 5'(10 + i); wb.lsu_data = 32'h80FF_7F01;
            wb.lsu_funct3 = f3s[i]; wb.lsu_byte_off = offs[i];
            #1; step();
            wb.lsu_valid = 1'b0;
            #1;
            checks++;
            if ({wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.err_illegal_load} !== {1'b1, 32'(10 + i), exps[i], 1'b0}) begin
                errors++; $display("FAIL load_ext[%0d] got we=%b addr=%h data=%h err=%b exp 1/%h/%h/0",
                    i, wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.err_illegal_load, 32'(10 + i), exps[i]);
            end
            step();
        end
    endtask

    task automatic test_dual();
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd3; wb.lsu_data = 32'hAAAA_AAAA;
        wb.lsu_funct3 = 3'b010; wb.lsu_byte_off = 2'd0;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_result = 32'h5555_5555;
        #1;
        checks++;
        if ({wb.alu_ready, wb.lsu_ready} !== 2'b11) begin
            errors++; $display("FAIL dual_ready0 got %b exp 11", {wb.alu_ready, wb.lsu_ready});
        end
        step(); #1;
        checks++;
        if ({wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask, wb.alu_ready, wb.lsu_ready}
            !== {1'b1, 32'd3, 32'hAAAA_AAAA, 32'h8, 2'b00}) begin
            errors++; $display("FAIL dual_first got we=%b addr=%h data=%h mask=%h rdy=%b exp 1/3/aaaaaaaa/8/00",
                wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask, {wb.alu_ready, wb.lsu_ready});
        end
        drive_idle();
        step();
        checks++;
        if ({wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask} !== {1'b1, 32'd3, 32'h5555_5555, 32'h8}) begin
            errors++; $display("FAIL dual_second got we=%b addr=%h data=%h mask=%h exp 1/3/55555555/8",
                wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask);
        end
        step();
        checks++;
        if ({wb.rf_write_en, wb.rd_pending_mask} !== 33'h0) begin
            errors++; $display("FAIL dual_drained got we=%b mask=%h exp 0/0", wb.rf_write_en, wb.rd_pending_mask);
        end
    endtask

    task automatic test_x0_illegal();
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_result = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (wb.alu_ready !== 1'b1) begin
            errors++; $display("FAIL x0_ready got %b exp 1", wb.alu_ready);
        end
        step();
        wb.alu_valid = 1'b0;
        #1;
        checks++;
        if ({wb.rf_write_en, wb.rd_pending_mask} !== 33'h0) begin
            errors++; $display("FAIL x0_nowrite got we=%b mask=%h exp 0/0", wb.rf_write_en, wb.rd_pending_mask);
        end
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd7; wb.lsu_data = 32'hDEAD_BEEF;
        wb.lsu_funct3 = 3'b011; wb.lsu_byte_off = 2'd1;
        #1; step();
        wb.lsu_valid = 1'b0;
        #1;
        checks++;
        if ({wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.err_illegal_load} !== {1'b1, 32'd7, 32'h0, 1'b1}) begin
            errors++; $display("FAIL illegal_write got we=%b addr=%h data=%h err=%b exp 1/7/0/1",
                wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.err_illegal_load);
        end
        step();
        checks++;
        if ({wb.rf_write_en, wb.err_illegal_load} !== 2'b00) begin
            errors++; $display("FAIL illegal_after got we=%b err=%b exp 0/0", wb.rf_write_en, wb.err_illegal_load);
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  iss_rd[$];
        logic [31:0] iss_data[$];
        int n_lsu = 0, n_alu = 0, cyc = 0;
        bit lf, af;
        log_rd.delete(); log_data.delete();
        while ((n_lsu < 4 || n_alu < 4 || m_rd.size() != 0) && cyc < 60) begin
            wb.lsu_valid = (n_lsu < 4); wb.lsu_rd = 5'(1 + n_lsu); wb.lsu_data = 32'hB000_0000 + n_lsu;
            wb.lsu_funct3 = 3'b010; wb.lsu_byte_off = 2'd0;
            wb.alu_valid = (n_alu < 4); wb.alu_rd = 5'(16 + n_alu); wb.alu_result = 32'hA000_0000 + n_alu;
            #1;
            checks++;
            if ({wb.rf_write_en, wb.rf_data_in} !== {(m_rd.size() != 0), (m_rd.size() != 0) ? m_data[0] : 32'h0}) begin
                errors++; $display("FAIL b2b_cycle[%0d] got we=%b data=%h", cyc, wb.rf_write_en, wb.rf_data_in);
            end
            tick(lf, af);
            if (lf) begin iss_rd.push_back(5'(1 + n_lsu)); iss_data.push_back(32'hB000_0000 + n_lsu); n_lsu++; end
            if (af) begin iss_rd.push_back(5'(16 + n_alu)); iss_data.push_back(32'hA000_0000 + n_alu); n_alu++; end
            cyc++;
        end
        drive_idle();
        step();
        checks++;
        if (cyc >= 60) begin
            errors++; $display("FAIL b2b_timeout got lsu=%0d alu=%0d exp 4/4", n_lsu, n_alu);
        end
        checks++;
        if (log_rd.size() != 8) begin
            errors++; $display("FAIL b2b_count got %0d exp 8", log_rd.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({log_rd[i], log_data[i]} !== {iss_rd[i], iss_data[i]}) begin
                    errors++; $display("FAIL b2b_order[%0d] got rd=%0d data=%h exp rd=%0d data=%h",
                        i, log_rd[i], log_data[i], iss_rd[i], iss_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        log_rd.delete(); log_data.delete();
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd4; wb.lsu_data = 32'h1111_1111;
        wb.lsu_funct3 = 3'b010; wb.lsu_byte_off = 2'd0;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd6; wb.alu_result = 32'h2222_2222;
        #1; step();
        rst = 1'b1;
        #1;
        checks++;
        if ({wb.rf_write_en, wb.alu_ready, wb.lsu_ready} !== 3'b000) begin
            errors++; $display("FAIL rstmid_during got we=%b rdy=%b exp 0/00", wb.rf_write_en, {wb.alu_ready, wb.lsu_ready});
        end
        step();
        rst = 1'b0;
        drive_idle();
        #1;
        checks++;
        if ({wb.rf_write_en, wb.rd_pending_mask, wb.err_illegal_load, wb.alu_ready, wb.lsu_ready} !== {1'b0, 32'h0, 1'b0, 2'b11}) begin
            errors++; $display("FAIL rstmid_after got we=%b mask=%h err=%b rdy=%b exp 0/0/0/11",
                wb.rf_write_en, wb.rd_pending_mask, wb.err_illegal_load, {wb.alu_ready, wb.lsu_ready});
        end
        step();
        checks++;
        if (wb.rf_write_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_nopulse got we=%b exp 0", wb.rf_write_en);
        end
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd12; wb.alu_result = 32'h0C0C_0C0C;
        #1; step();
        wb.alu_valid = 1'b0;
        step();
        checks++;
        if (log_rd.size() != 1) begin
            errors++; $display("FAIL rstmid_logsize got %0d exp 1", log_rd.size());
        end else begin
            checks++;
            if ({log_rd[0], log_data[0]} !== {5'd12, 32'h0C0C_0C0C}) begin
                errors++; $display("FAIL rstmid_fresh got rd=%0d data=%h exp 12/0c0c0c0c", log_rd[0], log_data[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e_mask, e_data, e_addr;
        bit e_we, e_ar, e_lr;
        for (int cyc = 0; cyc < 400; cyc++) begin
            wb.alu_valid = ($urandom_range(0, 1) == 1);
            wb.alu_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb.alu_result = $urandom;
            wb.lsu_valid = ($urandom_range(0, 1) == 1);
            wb.lsu_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb.lsu_data = $urandom;
            wb.lsu_funct3 = 3'($urandom_range(0, 7));
            wb.lsu_byte_off = 2'($urandom_range(0, 3));
            #1;
            e_we = (m_rd.size() != 0);
            e_addr = e_we ? 32'(m_rd[0]) : 32'h0;
            e_data = e_we ? m_data[0] : 32'h0;
            e_mask = 32'h0;
            foreach (m_rd[i]) e_mask = e_mask | (32'h1 << m_rd[i]);
            e_lr = (m_rd.size() <= 1);
            e_ar = wb.lsu_valid ? (m_rd.size() == 0) : (m_rd.size() <= 1);
            checks++;
            if ({wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask, wb.err_illegal_load, wb.alu_ready, wb.lsu_ready}
                !== {e_we, e_addr, e_data, e_mask, m_err, e_ar, e_lr}) begin
                errors++; $display("FAIL random[%0d] got we=%b addr=%h data=%h mask=%h err=%b ar=%b lr=%b exp we=%b addr=%h data=%h mask=%h err=%b ar=%b lr=%b",
                    cyc, wb.rf_write_en, wb.rf_write_addr, wb.rf_data_in, wb.rd_pending_mask, wb.err_illegal_load, wb.alu_ready, wb.lsu_ready,
                    e_we, e_addr, e_data, e_mask, m_err, e_ar, e_lr);
            end
            step();
        end
        drive_idle();
        step(); step(); step();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_load_ext();
        test_dual();
        test_x0_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
